multicycle_control: RTL and testbench

Multi-cycle control FSM for the LEGv8 processor. It sequences one instruction at a time through fetch, decode, execute, memory and write-back phases. It drives the sign-extender select (SignOp) and the ALU, register-file, memory and PC strobes. It stalls on instruction- and data-memory ready handshakes. Instruction memory, data memory, register file, ALU and sign extender sit outside the block; this block only configures and sequences them.

---
 rtl/legv8_defs.sv | 59 +++++
 rtl/legv8_opdecode.sv | 66 ++++++
 rtl/multicycle_control.sv | 148 ++++++++++++++
 tb/tb_multicycle_control.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_defs.sv
// rtl/legv8_defs.sv - shared LEGv8 opcode, class, state and control encodings
package legv8_defs;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_SUBI = 11'b11010001000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_MOVZ = 11'b11010010100;

  localparam logic [10:0] MASK_FULL = 11'b11111111111;
  localparam logic [10:0] MASK_IMM  = 11'b11111111110;
  localparam logic [10:0] MASK_CBZ  = 11'b11111111000;
  localparam logic [10:0] MASK_B    = 11'b11111100000;
  localparam logic [10:0] MASK_MOVZ = 11'b11111111100;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_R,
    CL_I,
    CL_LDUR,
    CL_STUR,
    CL_CBZ,
    CL_B,
    CL_MOVZ
  } class_e;

  localparam logic [2:0] SIGN_I    = 3'b000;
  localparam logic [2:0] SIGN_D    = 3'b001;
  localparam logic [2:0] SIGN_B    = 3'b010;
  localparam logic [2:0] SIGN_CBZ  = 3'b011;
  localparam logic [2:0] SIGN_MOVZ = 3'b100;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] pat,
                                    input logic [10:0] mask);
    return (op & mask) == pat;
  endfunction

endpackage

// File: rtl/legv8_opdecode.sv
// rtl/legv8_opdecode.sv - combinational opcode to datapath-control decode
module legv8_opdecode
  import legv8_defs::*;
(
  input  logic [10:0] i_opcode,
  output logic        o_valid,
  output class_e      o_class,
  output logic [2:0]  o_sign_op,
  output logic [3:0]  o_alu_op,
  output logic        o_alu_src,
  output logic        o_reg2loc
);

  always_comb begin
    o_valid   = 1'b1;
    o_class   = CL_R;
    o_sign_op = SIGN_I;
    o_alu_op  = ALU_AND;
    o_alu_src = 1'b0;
    o_reg2loc = 1'b0;
    if (op_match(i_opcode, OP_ADD, MASK_FULL)) begin
      o_alu_op = ALU_ADD;
    end else if (op_match(i_opcode, OP_SUB, MASK_FULL)) begin
      o_alu_op = ALU_SUB;
    end else if (op_match(i_opcode, OP_AND, MASK_FULL)) begin
      o_alu_op = ALU_AND;
    end else if (op_match(i_opcode, OP_ORR, MASK_FULL)) begin
      o_alu_op = ALU_ORR;
    end else if (op_match(i_opcode, OP_ADDI, MASK_IMM)) begin
      o_class   = CL_I;
      o_alu_op  = ALU_ADD;
      o_alu_src = 1'b1;
    end else if (op_match(i_opcode, OP_SUBI, MASK_IMM)) begin
      o_class   = CL_I;
      o_alu_op  = ALU_SUB;
      o_alu_src = 1'b1;
    end else if (op_match(i_opcode, OP_LDUR, MASK_FULL)) begin
      o_class   = CL_LDUR;
      o_sign_op = SIGN_D;
      o_alu_op  = ALU_ADD;
      o_alu_src = 1'b1;
    end else if (op_match(i_opcode, OP_STUR, MASK_FULL)) begin
      o_class   = CL_STUR;
      o_sign_op = SIGN_D;
      o_alu_op  = ALU_ADD;
      o_alu_src = 1'b1;
      o_reg2loc = 1'b1;
    end else if (op_match(i_opcode, OP_CBZ, MASK_CBZ)) begin
      o_class   = CL_CBZ;
      o_sign_op = SIGN_CBZ;
      o_alu_op  = ALU_PASSB;
      o_reg2loc = 1'b1;
    end else if (op_match(i_opcode, OP_B, MASK_B)) begin
      o_class   = CL_B;
      o_sign_op = SIGN_B;
    end else if (op_match(i_opcode, OP_MOVZ, MASK_MOVZ)) begin
      o_class   = CL_MOVZ;
      o_sign_op = SIGN_MOVZ;
      o_alu_op  = ALU_PASSB;
      o_alu_src = 1'b1;
    end else begin
      o_valid = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - LEGv8 multi-cycle sequencer: FSM, held controls, strobes
module multicycle_control
  import legv8_defs::*;
(
  input  logic        CLK,
  input  logic        resetl,
  input  logic [10:0] Opcode,
  input  logic        Zero,
  input  logic        IMemReady,
  input  logic        DMemReady,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic [2:0]  SignOp,
  output logic [3:0]  ALUOp,
  output logic        Illegal
);

  state_e     r_state;
  state_e     w_next_state;
  class_e     r_class;
  logic [2:0] r_sign_op;
  logic [3:0] r_alu_op;
  logic       r_alu_src;
  logic       r_reg2loc;
  logic       r_illegal;

  logic       w_dec_valid;
  class_e     w_dec_class;
  logic [2:0] w_dec_sign_op;
  logic [3:0] w_dec_alu_op;
  logic       w_dec_alu_src;
  logic       w_dec_reg2loc;

  logic w_ir_write, w_pc_write, w_pc_src, w_reg_write;
  logic w_mem_read, w_mem_write, w_mem_to_reg;

  legv8_opdecode u_opdecode (
    .i_opcode  (Opcode),
    .o_valid   (w_dec_valid),
    .o_class   (w_dec_class),
    .o_sign_op (w_dec_sign_op),
    .o_alu_op  (w_dec_alu_op),
    .o_alu_src (w_dec_alu_src),
    .o_reg2loc (w_dec_reg2loc)
  );

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) r_state <= ST_FETCH;
    else         r_state <= w_next_state;
  end

  // Decode results are captured once and held stable until the next DECODE.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_class   <= CL_R;
      r_sign_op <= SIGN_I;
      r_alu_op  <= ALU_AND;
      r_alu_src <= 1'b0;
      r_reg2loc <= 1'b0;
      r_illegal <= 1'b0;
    end else if (r_state == ST_DECODE) begin
      r_class   <= w_dec_class;
      r_sign_op <= w_dec_sign_op;
      r_alu_op  <= w_dec_alu_op;
      r_alu_src <= w_dec_alu_src;
      r_reg2loc <= w_dec_reg2loc;
      if (!w_dec_valid) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_ir_write = IMemReady;
        if (IMemReady) w_next_state = ST_DECODE;
      end
      ST_DECODE: w_next_state = w_dec_valid ? ST_EXEC : ST_HALT;
      ST_EXEC: begin
        case (r_class)
          CL_LDUR, CL_STUR: w_next_state = ST_MEM;
          CL_B: begin
            w_pc_write   = 1'b1;
            w_pc_src     = 1'b1;
            w_next_state = ST_FETCH;
          end
          CL_CBZ: begin
            w_pc_write   = 1'b1;
            w_pc_src     = Zero;
            w_next_state = ST_FETCH;
          end
          default: w_next_state = ST_WB;
        endcase
      end
      ST_MEM: begin
        w_mem_read  = (r_class == CL_LDUR);
        w_mem_write = (r_class == CL_STUR);
        if (DMemReady) begin
          if (r_class == CL_STUR) begin
            w_pc_write   = 1'b1;
            w_next_state = ST_FETCH;
          end else begin
            w_next_state = ST_WB;
          end
        end
      end
      ST_WB: begin
        w_reg_write  = 1'b1;
        w_pc_write   = 1'b1;
        w_mem_to_reg = (r_class == CL_LDUR);
        w_next_state = ST_FETCH;
      end
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_FETCH;
    endcase
  end

  // Gating with resetl keeps every strobe low for the whole reset window,
  // including IRWrite, which FETCH would otherwise pass through.
  assign IRWrite  = resetl & w_ir_write;
  assign PCWrite  = resetl & w_pc_write;
  assign PCSrc    = resetl & w_pc_src;
  assign RegWrite = resetl & w_reg_write;
  assign MemRead  = resetl & w_mem_read;
  assign MemWrite = resetl & w_mem_write;
  assign MemtoReg = resetl & w_mem_to_reg;

  assign SignOp  = r_sign_op;
  assign ALUOp   = r_alu_op;
  assign ALUSrc  = r_alu_src;
  assign Reg2Loc = r_reg2loc;
  assign Illegal = r_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed + randomized check of multicycle_control
module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        resetl;
  logic [10:0] Opcode;
  logic        Zero, IMemReady, DMemReady;
  logic        IRWrite, PCWrite, PCSrc, RegWrite, MemRead, MemWrite, MemtoReg;
  logic        Reg2Loc, ALUSrc, Illegal;
  logic [2:0]  SignOp;
  logic [3:0]  ALUOp;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [6:0] S_IR  = 7'b1000000;
  localparam logic [6:0] S_PCW = 7'b0100000;
  localparam logic [6:0] S_PCS = 7'b0010000;
  localparam logic [6:0] S_RW  = 7'b0001000;
  localparam logic [6:0] S_MR  = 7'b0000100;
  localparam logic [6:0] S_MW  = 7'b0000010;
  localparam logic [6:0] S_M2R = 7'b0000001;

  localparam int K_R = 0, K_I = 1, K_LDUR = 2, K_STUR = 3, K_CBZ = 4, K_B = 5, K_MOVZ = 6, K_BAD = 7;

  typedef struct packed {
    logic [2:0] kind;
    logic [2:0] sign;
    logic [3:0] alu;
    logic       src;
    logic       r2l;
    logic       ck_sign;
    logic       ck_alu;
    logic       ck_src;
    logic       ck_r2l;
  } dec_t;

  dec_t cur;
  logic [6:0] w_strobes;
  assign w_strobes = {IRWrite, PCWrite, PCSrc, RegWrite, MemRead, MemWrite, MemtoReg};

  multicycle_control dut (
    .CLK(CLK), .resetl(resetl), .Opcode(Opcode), .Zero(Zero),
    .IMemReady(IMemReady), .DMemReady(DMemReady),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .SignOp(SignOp), .ALUOp(ALUOp),
    .Illegal(Illegal)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference decode straight from the opcode table; unchecked fields are those left open.
  function automatic dec_t model(input logic [10:0] op);
    dec_t d;
    d = '0;
    casez (op)
      11'b10001011000: begin d.kind = K_R; d.alu = 4'b0010; d.ck_alu = 1; d.ck_src = 1; d.ck_r2l = 1; end
      11'b11001011000: begin d.kind = K_R; d.alu = 4'b0110; d.ck_alu = 1; d.ck_src = 1; d.ck_r2l = 1; end
      11'b10001010000: begin d.kind = K_R; d.alu = 4'b0000; d.ck_alu = 1; d.ck_src = 1; d.ck_r2l = 1; end
      11'b10101010000: begin d.kind = K_R; d.alu = 4'b0001; d.ck_alu = 1; d.ck_src = 1; d.ck_r2l = 1; end
      11'b1001000100?: begin d.kind = K_I; d.sign = 3'b000; d.alu = 4'b0010; d.src = 1;
                             d.ck_sign = 1; d.ck_alu = 1; d.ck_src = 1; end
      11'b1101000100?: begin d.kind = K_I; d.sign = 3'b000; d.alu = 4'b0110; d.src = 1;
                             d.ck_sign = 1; d.ck_alu = 1; d.ck_src = 1; end
      11'b11111000010: begin d.kind = K_LDUR; d.sign = 3'b001; d.alu = 4'b0010; d.src = 1;
                             d.ck_sign = 1; d.ck_alu = 1; d.ck_src = 1; end
      11'b11111000000: begin d.kind = K_STUR; d.sign = 3'b001; d.alu = 4'b0010; d.src = 1; d.r2l = 1;
                             d.ck_sign = 1; d.ck_alu = 1; d.ck_src = 1; d.ck_r2l = 1; end
      11'b10110100???: begin d.kind = K_CBZ; d.sign = 3'b011; d.alu = 4'b0111; d.r2l = 1;
                             d.ck_sign = 1; d.ck_alu = 1; d.ck_r2l = 1; end
      11'b000101?????: begin d.kind = K_B; d.sign = 3'b010; d.ck_sign = 1; end
      11'b110100101??: begin d.kind = K_MOVZ; d.sign = 3'b100; d.alu = 4'b0111; d.src = 1;
                             d.ck_sign = 1; d.ck_alu = 1; d.ck_src = 1; end
      default:         d.kind = K_BAD;
    endcase
    return d;
  endfunction

  function automatic logic [10:0] gen_op(input int k);
    logic [10:0] r;
    r = 11'($urandom);
    case (k)
      K_R: case ($urandom_range(0, 3))
             0: return 11'b10001011000;
             1: return 11'b11001011000;
             2: return 11'b10001010000;
             default: return 11'b10101010000;
           endcase
      K_I:    return ($urandom % 2) ? {10'b1001000100, r[0]} : {10'b1101000100, r[0]};
      K_LDUR: return 11'b11111000010;
      K_STUR: return 11'b11111000000;
      K_CBZ:  return {8'b10110100, r[2:0]};
      K_B:    return {6'b000101, r[4:0]};
      default: return {9'b110100101, r[1:0]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag);
    if (cur.ck_sign) chk({tag, "/SignOp"}, 32'(SignOp), 32'(cur.sign));
    if (cur.ck_alu)  chk({tag, "/ALUOp"}, 32'(ALUOp), 32'(cur.alu));
    if (cur.ck_src)  chk({tag, "/ALUSrc"}, 32'(ALUSrc), 32'(cur.src));
    if (cur.ck_r2l)  chk({tag, "/Reg2Loc"}, 32'(Reg2Loc), 32'(cur.r2l));
  endtask

  task automatic step(input bit imr, input bit dmr, input logic [6:0] exp,
                      input bit ck, input bit exp_ill, input string tag);
    @(negedge CLK);
    IMemReady = imr;
    DMemReady = dmr;
    #1;
    chk({tag, "/strobes"}, 32'(w_strobes), 32'(exp));
    chk({tag, "/Illegal"}, 32'(Illegal), 32'(exp_ill));
    if (ck) chk_ctrl(tag);
  endtask

  function automatic bit rb();
    return bit'($urandom % 2);
  endfunction

  // Walks one instruction through its expected phase sequence with given wait states.
  task automatic run_instr(input logic [10:0] op, input bit z, input int fw, input int mw);
    logic [6:0] e;
    Opcode = op;
    Zero   = z;
    cur    = model(op);
    for (int i = 0; i < fw; i++) step(1'b0, rb(), 7'b0, 1'b0, 1'b0, "fetch_wait");
    step(1'b1, rb(), S_IR, 1'b0, 1'b0, "fetch");
    step(rb(), rb(), 7'b0, 1'b0, 1'b0, "decode");
    e = 7'b0;
    if (cur.kind == K_B)   e = S_PCW | S_PCS;
    if (cur.kind == K_CBZ) e = S_PCW | (z ? S_PCS : 7'b0);
    step(rb(), rb(), e, 1'b1, 1'b0, "exec");
    if (cur.kind == K_LDUR || cur.kind == K_STUR) begin
      e = (cur.kind == K_LDUR) ? S_MR : S_MW;
      for (int i = 0; i < mw; i++) step(rb(), 1'b0, e, 1'b1, 1'b0, "mem_wait");
      step(rb(), 1'b1, e | ((cur.kind == K_STUR) ? S_PCW : 7'b0), 1'b1, 1'b0, "mem_done");
    end
    if (cur.kind == K_R || cur.kind == K_I || cur.kind == K_MOVZ || cur.kind == K_LDUR)
      step(rb(), rb(), S_RW | S_PCW | ((cur.kind == K_LDUR) ? S_M2R : 7'b0), 1'b1, 1'b0, "wb");
  endtask

  initial begin
    resetl = 1'b0; Opcode = '0; Zero = 1'b0; IMemReady = 1'b1; DMemReady = 1'b1;
    #12;
    chk("reset/strobes", 32'(w_strobes), 32'd0);
    chk("reset/SignOp", 32'(SignOp), 32'd0);
    chk("reset/ALUOp", 32'(ALUOp), 32'd0);
    chk("reset/ALUSrc", 32'(ALUSrc), 32'd0);
    chk("reset/Reg2Loc", 32'(Reg2Loc), 32'd0);
    chk("reset/Illegal", 32'(Illegal), 32'd0);
    @(negedge CLK);
    resetl = 1'b1; IMemReady = 1'b0;

    run_instr(11'b10001011000, 1'b0, 0, 0);  // ADD
    run_instr(11'b11111000010, 1'b0, 0, 3);  // LDUR, 3 data wait states
    run_instr(11'b10110100000, 1'b1, 0, 0);  // CBZ taken
    run_instr(11'b10110100000, 1'b0, 0, 0);  // CBZ not taken
    run_instr(11'b11010010100, 1'b0, 0, 0);  // MOVZ
    run_instr(11'b00010100000, 1'b0, 1, 0);  // B
    run_instr(11'b11111000000, 1'b0, 2, 1);  // STUR

    for (int n = 0; n < 40; n++)
      run_instr(gen_op($urandom_range(0, 6)), rb(), $urandom_range(0, 2), $urandom_range(0, 3));

    // Unrecognized opcode: HALT with Illegal set and all strobes quiet
    Opcode = 11'b00000000000;
    cur = model(Opcode);
    chk("model/bad_kind", 32'(cur.kind), 32'(K_BAD));
    step(1'b1, rb(), S_IR, 1'b0, 1'b0, "ill_fetch");
    step(rb(), rb(), 7'b0, 1'b0, 1'b0, "ill_decode");
    for (int i = 0; i < 20; i++) begin
      Zero = rb();
      step(rb(), rb(), 7'b0, 1'b0, 1'b1, "halt");
    end
    @(negedge CLK);
    resetl = 1'b0; IMemReady = 1'b0;
    #1;
    chk("halt_reset/Illegal", 32'(Illegal), 32'd0);
    @(negedge CLK);
    resetl = 1'b1;
    run_instr(11'b10101010000, 1'b0, 0, 0);  // ORR after recovery

    // STUR abandoned by reset while stalled in MEM
    Opcode = 11'b11111000000;
    cur = model(Opcode);
    step(1'b1, rb(), S_IR, 1'b0, 1'b0, "st_fetch");
    step(rb(), rb(), 7'b0, 1'b0, 1'b0, "st_decode");
    step(rb(), rb(), 7'b0, 1'b1, 1'b0, "st_exec");
    step(rb(), 1'b0, S_MW, 1'b1, 1'b0, "st_mem_wait");
    step(rb(), 1'b0, S_MW, 1'b1, 1'b0, "st_mem_wait2");
    #2;
    resetl = 1'b0;
    #1;
    chk("st_rst/strobes", 32'(w_strobes), 32'd0);
    chk("st_rst/SignOp", 32'(SignOp), 32'd0);
    chk("st_rst/Reg2Loc", 32'(Reg2Loc), 32'd0);
    DMemReady = 1'b1; IMemReady = 1'b1;
    @(negedge CLK);
    #1;
    chk("st_rst_hold/strobes", 32'(w_strobes), 32'd0);
    @(negedge CLK);
    resetl = 1'b1; IMemReady = 1'b0;
    run_instr(11'b10001011000, 1'b0, 2, 0);  // ADD, IRWrite follows IMemReady

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
